// File: rtl/hazard_control_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_control_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } hcu_state_e;

   localparam int unsigned DEF_FLUSH_CYCLES       = 2;
   localparam int unsigned DEF_MEM_TIMEOUT_CYCLES = 255;
   localparam int unsigned DEF_COUNTER_WIDTH      = 32;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side hazard inputs and the stall/clear/perf outputs of the controller.
interface hazard_control_unit_if #(
   parameter int unsigned COUNTER_WIDTH = hazard_control_pkg::DEF_COUNTER_WIDTH
);
   logic [4:0]               RS1_ADDRESS;
   logic [4:0]               RS2_ADDRESS;
   logic [4:0]               RD_ADDRESS_EX;
   logic                     RD_WRITE_ENABLE_EX;
   logic [2:0]               DATA_CACHE_READ_EX;
   logic                     BRANCH_TAKEN;
   logic                     MEMORY_ACCESS;
   logic                     DATA_CACHE_READY;
   logic                     INSTRUCTION_CACHE_READY;

   logic                     STALL_PROGRAM_COUNTER;
   logic                     STALL_DECODING_STAGE;
   logic                     CLEAR_DECODING_STAGE;
   logic                     STALL_EXECUTION_STAGE;
   logic                     CLEAR_EXECUTION_STAGE;
   logic                     STALL_MEMORY_STAGE;
   logic                     CLEAR_WRITE_BACK_STAGE;
   logic [COUNTER_WIDTH-1:0] STALL_CYCLE_COUNT;
   logic [COUNTER_WIDTH-1:0] FLUSH_COUNT;
   logic                     MEM_TIMEOUT;

   modport slave (
      input  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_EX, RD_WRITE_ENABLE_EX,
             DATA_CACHE_READ_EX, BRANCH_TAKEN, MEMORY_ACCESS, DATA_CACHE_READY,
             INSTRUCTION_CACHE_READY,
      output STALL_PROGRAM_COUNTER, STALL_DECODING_STAGE, CLEAR_DECODING_STAGE,
             STALL_EXECUTION_STAGE, CLEAR_EXECUTION_STAGE, STALL_MEMORY_STAGE,
             CLEAR_WRITE_BACK_STAGE, STALL_CYCLE_COUNT, FLUSH_COUNT, MEM_TIMEOUT
   );

   modport master (
      output RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_EX, RD_WRITE_ENABLE_EX,
             DATA_CACHE_READ_EX, BRANCH_TAKEN, MEMORY_ACCESS, DATA_CACHE_READY,
             INSTRUCTION_CACHE_READY,
      input  STALL_PROGRAM_COUNTER, STALL_DECODING_STAGE, CLEAR_DECODING_STAGE,
             STALL_EXECUTION_STAGE, CLEAR_EXECUTION_STAGE, STALL_MEMORY_STAGE,
             CLEAR_WRITE_BACK_STAGE, STALL_CYCLE_COUNT, FLUSH_COUNT, MEM_TIMEOUT
   );

endinterface

// File: rtl/saturating_event_counter.sv
// Event counter that sticks at all-ones; clear takes precedence over increment.
module saturating_event_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/clear sequencing for the 5-stage pipeline: load-use, branch flush,
// data-cache freeze and icache miss, plus perf counters and a timeout flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; load-use and icache-miss checks active
//   FLUSH    | clearing decode for the remaining post-branch bubbles
//   MEM_WAIT | pipeline frozen on a data-cache miss; r_ret_flush = resume
module hazard_control_unit
   import hazard_control_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES       = DEF_FLUSH_CYCLES,
   parameter int unsigned MEM_TIMEOUT_CYCLES = DEF_MEM_TIMEOUT_CYCLES,
   parameter int unsigned COUNTER_WIDTH      = DEF_COUNTER_WIDTH
) (
   input  logic           CLK,
   input  logic           RST_N,
   hazard_control_unit_if.slave hif
);

   localparam int unsigned FCW = cnt_width(FLUSH_CYCLES);
   localparam int unsigned WCW = cnt_width(MEM_TIMEOUT_CYCLES);

   hcu_state_e         r_state, w_state_nxt;
   logic               r_ret_flush, w_ret_flush_nxt;
   logic [FCW-1:0]     r_flush_cnt, w_flush_cnt_nxt;
   logic               r_mem_timeout;
   logic [WCW-1:0]     w_wait_cnt;
   logic [COUNTER_WIDTH-1:0] w_stall_cnt;
   logic [COUNTER_WIDTH-1:0] w_flush_evt_cnt;

   logic w_freeze, w_load_use, w_eff_flush, w_flush_evt;
   logic w_stall_pc, w_stall_dec, w_clear_dec, w_stall_ex, w_clear_ex;
   logic w_stall_mem, w_clear_wb;

   assign w_freeze   = hif.MEMORY_ACCESS & ~hif.DATA_CACHE_READY;
   assign w_load_use = (hif.DATA_CACHE_READ_EX != 3'd0) & hif.RD_WRITE_ENABLE_EX &
                       (hif.RD_ADDRESS_EX != 5'd0) &
                       ((hif.RD_ADDRESS_EX == hif.RS1_ADDRESS) |
                        (hif.RD_ADDRESS_EX == hif.RS2_ADDRESS));
   // Leaving MEM_WAIT behaves exactly like the state that was frozen.
   assign w_eff_flush = (r_state == FLUSH) | ((r_state == MEM_WAIT) & r_ret_flush);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= RUN;
         r_ret_flush <= 1'b0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_flush <= w_ret_flush_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ret_flush_nxt = r_ret_flush;
      w_flush_cnt_nxt = r_flush_cnt;
      w_flush_evt     = 1'b0;
      w_stall_pc      = 1'b0;
      w_stall_dec     = 1'b0;
      w_clear_dec     = 1'b0;
      w_stall_ex      = 1'b0;
      w_clear_ex      = 1'b0;
      w_stall_mem     = 1'b0;
      w_clear_wb      = 1'b0;

      if (w_freeze) begin
         w_stall_pc  = 1'b1;
         w_stall_dec = 1'b1;
         w_stall_ex  = 1'b1;
         w_stall_mem = 1'b1;
         w_clear_wb  = 1'b1;
         w_state_nxt = MEM_WAIT;
         if (r_state != MEM_WAIT) begin
            w_ret_flush_nxt = (r_state == FLUSH);
         end
      end else if (hif.BRANCH_TAKEN) begin
         w_clear_dec     = 1'b1;
         w_clear_ex      = 1'b1;
         w_flush_evt     = 1'b1;
         w_flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
         w_state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (w_eff_flush) begin
         w_clear_dec     = 1'b1;
         w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
         w_state_nxt     = (r_flush_cnt <= FCW'(1)) ? RUN : FLUSH;
      end else begin
         w_state_nxt = RUN;
         if (w_load_use) begin
            w_stall_pc  = 1'b1;
            w_stall_dec = 1'b1;
            w_clear_ex  = 1'b1;
         end else if (!hif.INSTRUCTION_CACHE_READY) begin
            w_stall_pc  = 1'b1;
            w_clear_dec = 1'b1;
         end
      end

      // Held in reset the pipeline is drained: nothing stalls, everything clears.
      if (!RST_N) begin
         w_stall_pc  = 1'b0;
         w_stall_dec = 1'b0;
         w_stall_ex  = 1'b0;
         w_stall_mem = 1'b0;
         w_clear_dec = 1'b1;
         w_clear_ex  = 1'b1;
         w_clear_wb  = 1'b1;
      end
   end

   saturating_event_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
      .clk     (CLK),
      .rst_n   (RST_N),
      .i_inc   (w_stall_pc),
      .i_clr   (1'b0),
      .o_count (w_stall_cnt)
   );

   saturating_event_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
      .clk     (CLK),
      .rst_n   (RST_N),
      .i_inc   (w_flush_evt),
      .i_clr   (1'b0),
      .o_count (w_flush_evt_cnt)
   );

   saturating_event_counter #(.WIDTH(WCW)) u_wait_cnt (
      .clk     (CLK),
      .rst_n   (RST_N),
      .i_inc   (w_freeze),
      .i_clr   (~w_freeze),
      .o_count (w_wait_cnt)
   );

   // Set on the same edge the wait counter reaches the limit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mem_timeout <= 1'b0;
      end else if (w_freeze && (w_wait_cnt >= WCW'(MEM_TIMEOUT_CYCLES - 1))) begin
         r_mem_timeout <= 1'b1;
      end
   end

   assign hif.STALL_PROGRAM_COUNTER  = w_stall_pc;
   assign hif.STALL_DECODING_STAGE   = w_stall_dec;
   assign hif.CLEAR_DECODING_STAGE   = w_clear_dec;
   assign hif.STALL_EXECUTION_STAGE  = w_stall_ex;
   assign hif.CLEAR_EXECUTION_STAGE  = w_clear_ex;
   assign hif.STALL_MEMORY_STAGE     = w_stall_mem;
   assign hif.CLEAR_WRITE_BACK_STAGE = w_clear_wb;
   assign hif.STALL_CYCLE_COUNT      = w_stall_cnt;
   assign hif.FLUSH_COUNT            = w_flush_evt_cnt;
   assign hif.MEM_TIMEOUT            = r_mem_timeout;

endmodule
